// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/ready controller for a STAGES-deep datapath with bubble collapse, clocked on the falling edge.
// Defining PIPE_CTRL_STATS_EN adds the done_cnt/stall_cnt statistics outputs.
module pipe_ctrl #(
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [4:0]        count,
`ifdef PIPE_CTRL_STATS_EN
    output logic [15:0]       done_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    logic [STAGES-1:0] r_v;
    logic [4:0]        r_count;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_vNext;
    logic [STAGES-1:0] w_load;
    logic              w_live;
    logic              w_accept;
    logic              w_emit;

    // A stage is ready unless it and every stage after it is full and the sink is stalled.
    always_comb begin : readyChain
        logic fullAbove;
        fullAbove = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            fullAbove = fullAbove & r_v[i];
            w_rdy[i]  = out_ready | ~fullAbove;
        end
    end

    always_comb begin
        w_vNext   = r_v;
        w_load    = '0;
        if (w_rdy[0]) begin
            w_vNext[0] = in_valid;
        end
        w_load[0] = w_rdy[0] & in_valid;
        for (int i = 1; i < STAGES; i++) begin
            if (w_rdy[i]) begin
                w_vNext[i] = r_v[i-1];
            end
            w_load[i] = w_rdy[i] & r_v[i-1];
        end
    end

    // Gating with reset keeps the handshake quiet while the controller is held in reset.
    assign w_live      = reset & ~flush;
    assign in_ready    = w_rdy[0] & w_live;
    assign stage_en    = w_load & {STAGES{w_live}};
    assign out_valid   = r_v[STAGES-1];
    assign stage_valid = r_v;
    assign count       = r_count;
    assign busy        = (r_count != 5'd0);
    assign w_accept    = in_valid & in_ready;
    assign w_emit      = out_valid & out_ready & ~flush;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_v     <= '0;
            r_count <= 5'd0;
        end else if (flush) begin
            r_v     <= '0;
            r_count <= 5'd0;
        end else begin
            r_v <= w_vNext;
            if (w_accept && !w_emit) begin
                r_count <= r_count + 5'd1;
            end else if (!w_accept && w_emit) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] r_doneCnt;
    logic [15:0] r_stallCnt;

    // Statistics survive flush; only reset clears them. done wraps, stall saturates.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_doneCnt  <= 16'd0;
            r_stallCnt <= 16'd0;
        end else begin
            if (w_emit) begin
                r_doneCnt <= r_doneCnt + 16'd1;
            end
            if (out_valid && !out_ready && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
        end
    end

    assign done_cnt  = r_doneCnt;
    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against an item-movement model of the pipeline.
// Statistics checks are compiled in when PIPE_CTRL_STATS_EN is defined.
module tb_pipe_ctrl;

    localparam int STAGES = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic              flush;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic [4:0]        count;
    logic              busy;
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0]       done_cnt;
    logic [15:0]       stall_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;
    bit checkOn    = 0;

    // Model state: which stages hold an item, plus running totals.
    bit [STAGES-1:0] occ        = '0;
    int              items      = 0;
    int              doneModel  = 0;
    int              stallModel = 0;

    pipe_ctrl #(.STAGES(STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .flush       (flush),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .count       (count),
`ifdef PIPE_CTRL_STATS_EN
        .done_cnt    (done_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit iv, input bit ordy, input bit fl);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
    endtask

    // Walk items forward from the sink: the last item leaves if the sink takes it,
    // each item steps into a freed slot, and a new item enters stage 0 if it is free.
    function automatic void predict(input bit iv, input bit ordy, input bit fl, input bit rst,
                                    output bit [STAGES-1:0] expEn, output bit expInReady,
                                    output bit emit, output bit [STAGES-1:0] nextOcc);
        bit [STAGES-1:0] slot;
        slot  = occ;
        expEn = '0;
        emit  = occ[STAGES-1] && ordy;
        if (emit) slot[STAGES-1] = 1'b0;
        for (int i = STAGES - 1; i >= 1; i--) begin
            if (!slot[i] && slot[i-1]) begin
                slot[i]   = 1'b1;
                slot[i-1] = 1'b0;
                expEn[i]  = 1'b1;
            end
        end
        expInReady = !slot[0];
        if (iv && expInReady) begin
            slot[0]  = 1'b1;
            expEn[0] = 1'b1;
        end
        nextOcc = slot;
        if (fl || !rst) begin
            expEn      = '0;
            expInReady = 1'b0;
            emit       = 1'b0;
            nextOcc    = '0;
        end
    endfunction

    always @(negedge clk or negedge reset) begin : modelUpdate
        bit [STAGES-1:0] en;
        bit [STAGES-1:0] nx;
        bit              ir;
        bit              em;
        if (!reset) begin
            occ        = '0;
            items      = 0;
            doneModel  = 0;
            stallModel = 0;
        end else begin
            predict(in_valid, out_ready, flush, 1'b1, en, ir, em, nx);
            if (occ[STAGES-1] && !out_ready && stallModel < 65535) stallModel++;
            if (em) doneModel = (doneModel + 1) % 65536;
            if (flush) items = 0;
            else items = items + ((in_valid && ir) ? 1 : 0) - (em ? 1 : 0);
            occ = nx;
        end
    end

    always @(posedge clk) begin : compareProc
        bit [STAGES-1:0] en;
        bit [STAGES-1:0] nx;
        bit              ir;
        bit              em;
        if (checkOn) begin
            predict(in_valid, out_ready, flush, reset, en, ir, em, nx);
            checkOutput("cyc in_ready",    in_ready,    ir);
            checkOutput("cyc stage_en",    stage_en,    en);
            checkOutput("cyc stage_valid", stage_valid, occ);
            checkOutput("cyc out_valid",   out_valid,   occ[STAGES-1]);
            checkOutput("cyc count",       count,       items);
            checkOutput("cyc busy",        busy,        items != 0);
`ifdef PIPE_CTRL_STATS_EN
            checkOutput("cyc done_cnt",    done_cnt,    doneModel);
            checkOutput("cyc stall_cnt",   stall_cnt,   stallModel);
`endif
        end
    end

    task automatic drain();
        for (int k = 0; k < STAGES + 1; k++) applyStimulus(0, 1, 0);
    endtask

    initial begin
        int acc;
        int emi;
        int irLow;
        bit rIv;
        bit rOrdy;
        bit rFl;

        clk       = 1'b1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;

        #2;
        checkOutput("rst in_ready",    in_ready,    0);
        checkOutput("rst stage_en",    stage_en,    0);
        checkOutput("rst out_valid",   out_valid,   0);
        checkOutput("rst stage_valid", stage_valid, 0);
        checkOutput("rst count",       count,       0);
        checkOutput("rst busy",        busy,        0);

        @(negedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        checkOn  = 1'b1;
        applyStimulus(0, 1, 0);

        $display("[TB] single item latency");
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(k == 1, 1, 0);
            checkOutput("lat out_valid", out_valid, (k == STAGES) ? 1 : 0);
            checkOutput("lat count",     count,     (k <= STAGES) ? 1 : 0);
        end

        $display("[TB] streaming");
        acc = 0; emi = 0; irLow = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) emi++;
            if (!in_ready) irLow++;
            @(negedge clk);
            #1;
        end
        checkOutput("stream accepts", acc, 20);
        checkOutput("stream emits",   emi, 16);
        checkOutput("stream count",   count, 4);
        checkOutput("stream ir low",  irLow, 0);
        drain();

        $display("[TB] fill and stall");
        for (int k = 0; k < STAGES; k++) applyStimulus(1, 0, 0);
        checkOutput("fill count",    count,       4);
        checkOutput("fill sv",       stage_valid, 4'b1111);
        checkOutput("fill in_ready", in_ready,    0);
        checkOutput("fill stage_en", stage_en,    0);
        applyStimulus(1, 0, 0);
        checkOutput("hold sv",    stage_valid, 4'b1111);
        checkOutput("hold count", count,       4);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checkOutput("full in_ready", in_ready, 1);
        checkOutput("full stage_en", stage_en, 4'b1111);
        @(negedge clk);
        #1;
        checkOutput("full pass count", count, 4);
        drain();

        $display("[TB] bubble collapse");
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("bubble sv", stage_valid, 4'b1010);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("collapse sv",    stage_valid, 4'b1111);
        checkOutput("collapse count", count,       4);
        drain();

        $display("[TB] flush");
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("preflush sv",    stage_valid, 4'b1011);
        checkOutput("preflush count", count,       3);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
        #1;
        checkOutput("flush in_ready", in_ready, 0);
        checkOutput("flush stage_en", stage_en, 0);
        @(negedge clk);
        #1;
        checkOutput("postflush sv",    stage_valid, 0);
        checkOutput("postflush count", count,       0);
        checkOutput("postflush busy",  busy,        0);
        applyStimulus(0, 1, 0);

        $display("[TB] reset mid-stream");
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0);
        checkOutput("prereset count", count, 3);
        reset = 1'b0;
        #1;
        checkOutput("async out_valid", out_valid,   0);
        checkOutput("async sv",        stage_valid, 0);
        checkOutput("async count",     count,       0);
        checkOutput("async busy",      busy,        0);
        checkOutput("async in_ready",  in_ready,    0);
        checkOutput("async stage_en",  stage_en,    0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1, 0, 0);
        checkOutput("post reset sv",    stage_valid, 4'b0001);
        checkOutput("post reset count", count,       1);
        drain();

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            rIv   = ($urandom_range(0, 3) != 0);
            rOrdy = ($urandom_range(0, 2) != 0);
            rFl   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                applyStimulus(rIv, rOrdy, rFl);
                #3;
                reset = 1'b1;
            end else begin
                applyStimulus(rIv, rOrdy, rFl);
            end
        end

        $display("[TB] statistics");
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < STAGES; k++) applyStimulus(1, 0, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0);
        checkOutput("stats sv", stage_valid, 4'b1000);
`ifdef PIPE_CTRL_STATS_EN
        checkOutput("stats stall", stall_cnt, 10);
        checkOutput("stats done",  done_cnt,  3);
`endif
        applyStimulus(0, 1, 1);
        checkOutput("stats flush sv", stage_valid, 0);
`ifdef PIPE_CTRL_STATS_EN
        checkOutput("stats flush stall", stall_cnt, 10);
        checkOutput("stats flush done",  done_cnt,  3);
`endif
        applyStimulus(0, 1, 0);

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
